// File: rtl/alu_seq_ctrl_if.sv
// Instruction-fetch handshake and ALU operand/result bus between the sequencer
// (master) and the instruction memory / ALU pair (slave).
interface alu_seq_ctrl_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_data;

    logic [3:0] alu_opcode;
    logic [7:0] alu_rs1;
    logic [7:0] alu_rs2;
    logic [1:0] alu_constant;
    logic [7:0] alu_out;
    logic       alu_overflow;
    logic       alu_branch_taken;

    modport master (
        output imem_req, imem_addr, alu_opcode, alu_rs1, alu_rs2, alu_constant,
        input  imem_ack, imem_data, alu_out, alu_overflow, alu_branch_taken
    );

    modport slave (
        input  imem_req, imem_addr, alu_opcode, alu_rs1, alu_rs2, alu_constant,
        output imem_ack, imem_data, alu_out, alu_overflow, alu_branch_taken
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: fetches 9-bit instructions, drives the external ALU,
// and retires results into a 4x8 register file and the PC.
module alu_seq_ctrl (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    alu_seq_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  halted,
    output logic [7:0]            pc,
    output logic                  ov_flag,
    output logic [15:0]           instr_count,
    input  logic [1:0]            dbg_sel,
    output logic [7:0]            dbg_data
);
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    state_t              state;
    logic [8:0]          ir;
    logic [DATA_W-1:0]   regs [4];
    logic [DATA_W-1:0]   res_p1;
    logic                ov_p1;
    logic                bt_p1;

    logic [3:0]          op;
    logic [1:0]          rd;
    logic [1:0]          rs;
    logic                reserved_unused;

    function automatic logic is_write(input logic [3:0] o);
        return (o <= 4'd4) || ((o >= 4'd6) && (o <= 4'd10)) || (o == 4'd12);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign op              = ir[8:5];
    assign rd              = ir[4:3];
    assign rs              = ir[2:1];
    assign reserved_unused = ir[0];

    // ALU operands come straight from IR and the register file, so they stay
    // stable for the whole of EXEC and WB.
    assign bus.alu_opcode   = op;
    assign bus.alu_rs1      = regs[rd];
    assign bus.alu_rs2      = regs[rs];
    assign bus.alu_constant = rs;
    assign bus.imem_addr    = pc;
    assign dbg_data         = regs[dbg_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            ir           <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            res_p1       <= '0;
            ov_p1        <= 1'b0;
            bt_p1        <= 1'b0;
            bus.imem_req <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            ov_flag      <= 1'b0;
            instr_count  <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state        <= FETCH;
                        pc           <= '0;
                        instr_count  <= '0;
                        ov_flag      <= 1'b0;
                        bus.imem_req <= 1'b1;
                        busy         <= 1'b1;
                        halted       <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir           <= bus.imem_data;
                        bus.imem_req <= 1'b0;
                        state        <= EXEC;
                    end
                end
                // EXEC -> WB: capture the ALU response
                EXEC: begin
                    res_p1 <= bus.alu_out;
                    ov_p1  <= bus.alu_overflow;
                    bt_p1  <= bus.alu_branch_taken;
                    state  <= WB;
                end
                // WB -> next: architectural update
                WB: begin
                    instr_count <= sat_inc(instr_count);
                    if (is_write(op)) regs[rd] <= res_p1;
                    if (op == 4'd0) ov_flag <= ov_p1;
                    case (op)
                        4'd5:    pc <= bt_p1 ? regs[rs] : pc + 8'd1;
                        4'd11:   pc <= res_p1;
                        4'd15:   pc <= pc;
                        default: pc <= pc + 8'd1;
                    endcase
                    if (op == 4'd15) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state        <= FETCH;
                        bus.imem_req <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: instruction-level reference model plus a small ALU
// model, directed scenarios followed by a randomized program run.
module tb_alu_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;
    logic [7:0]  pc;
    logic        busy, halted, ov_flag;
    logic [15:0] instr_count;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .ov_flag     (ov_flag),
        .instr_count (instr_count),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [7:0]  m_reg [4];
    logic [7:0]  m_pc;
    logic        m_ov;
    logic [15:0] m_cnt;
    logic [8:0]  m_ir;
    logic        e_busy, e_halted, e_req;
    logic [8:0]  prog [256];
    logic        rnd_start = 1'b0;
    logic        junk_ov = 1'b0, junk_bt = 1'b0;
    logic [9:0]  alu_res;

    // ALU model: returns {overflow, taken, result}
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [1:0] c);
        logic [8:0] s;
        logic [7:0] r;
        logic ov, bt;
        s = {1'b0, a} + {1'b0, b};
        r = 8'h00; ov = 1'b0; bt = 1'b0;
        case (op)
            4'd0:  begin r = s[7:0]; ov = s[8]; end
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  begin r = a; bt = (a == 8'h00); end
            4'd6:  r = a << c;
            4'd7:  r = a >> c;
            4'd8:  r = a + {6'd0, c};
            4'd9:  r = ~a;
            4'd10: r = b;
            4'd11: begin r = a; bt = 1'b1; end
            4'd12: r = a + 8'd1;
            default: r = 8'h00;
        endcase
        return {ov, bt, r};
    endfunction

    // Undefined overflow/taken outputs are driven with noise the sequencer must ignore.
    always_comb begin
        alu_res = alu_f(bus.alu_opcode, bus.alu_rs1, bus.alu_rs2, bus.alu_constant);
        bus.alu_out = alu_res[7:0];
        bus.alu_overflow = (bus.alu_opcode == 4'd0) ? alu_res[9] : junk_ov;
        bus.alu_branch_taken = (bus.alu_opcode == 4'd5 || bus.alu_opcode == 4'd11)
                               ? alu_res[8] : junk_bt;
    end

    always @(negedge clk) begin
        junk_ov <= 1'($urandom);
        junk_bt <= 1'($urandom);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("busy", 16'(busy), 16'(e_busy));
        chk("halted", 16'(halted), 16'(e_halted));
        chk("imem_req", 16'(bus.imem_req), 16'(e_req));
        if (e_req) chk("imem_addr", 16'(bus.imem_addr), 16'(m_pc));
        chk("pc", 16'(pc), 16'(m_pc));
        chk("ov_flag", 16'(ov_flag), 16'(m_ov));
        chk("instr_count", instr_count, m_cnt);
        chk("alu_opcode", 16'(bus.alu_opcode), 16'(m_ir[8:5]));
        chk("alu_rs1", 16'(bus.alu_rs1), 16'(m_reg[m_ir[4:3]]));
        chk("alu_rs2", 16'(bus.alu_rs2), 16'(m_reg[m_ir[2:1]]));
        chk("alu_constant", 16'(bus.alu_constant), 16'(m_ir[2:1]));
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("reg%0d", i), 16'(dbg_data), 16'(m_reg[i]));
        end
    end

    function automatic logic [8:0] enc(input int op, input int rd, input int rs);
        return {4'(op), 2'(rd), 2'(rs), 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pc = 8'h00; m_ov = 1'b0; m_cnt = 16'h0; m_ir = 9'h000;
        e_busy = 1'b0; e_halted = 1'b0; e_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_pc = 8'h00; m_cnt = 16'h0; m_ov = 1'b0;
        e_busy = 1'b1; e_halted = 1'b0; e_req = 1'b1;
    endtask

    function automatic logic rs_pick();
        return rnd_start && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic retire(input logic [8:0] ins);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [9:0] r;
        op = ins[8:5]; rd = ins[4:3]; rs = ins[2:1];
        r = alu_f(op, m_reg[rd], m_reg[rs], rs);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (op == 4'd15) begin
            e_halted = 1'b1; e_busy = 1'b0; e_req = 1'b0;
        end else begin
            if (op == 4'd5 && m_reg[rd] == 8'h00) m_pc = m_reg[rs];
            else if (op == 4'd11) m_pc = m_reg[rd];
            else m_pc = m_pc + 8'd1;
            if (op inside {[0:4], [6:10], 12}) m_reg[rd] = r[7:0];
            if (op == 4'd0) m_ov = r[9];
            e_req = 1'b1;
        end
    endtask

    task automatic do_instr(input int waits);
        logic [8:0] ins;
        for (int w = 0; w < waits; w++) begin
            bus.imem_ack = 1'b0;
            bus.imem_data = 9'($urandom);
            start = rs_pick();
            cyc();
        end
        ins = prog[m_pc];
        bus.imem_ack = 1'b1;
        bus.imem_data = ins;
        start = rs_pick();
        cyc();
        bus.imem_ack = 1'b0;
        bus.imem_data = 9'($urandom);
        m_ir = ins; e_req = 1'b0;
        start = rs_pick();
        cyc();
        start = rs_pick();
        cyc();
        start = 1'b0;
        retire(ins);
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_data = 9'h000;
        for (int i = 0; i < 256; i++) prog[i] = 9'h000;
        model_reset();
        #1 rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_pc", 16'(pc), 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0000);

        // Add at pc0, halt at pc1; a stray start during busy is ignored
        prog[0] = enc(0, 0, 0);
        prog[1] = enc(15, 0, 0);
        rnd_start = 1'b1;
        pulse_start();
        do_instr(0);
        do_instr(0);
        chk("t1_halted", 16'(halted), 16'h0001);
        chk("t1_pc", 16'(pc), 16'h0001);
        chk("t1_count", instr_count, 16'd2);
        cyc();

        // Build R1=F0, then F0+F0 overflows; xor keeps ov_flag
        prog[0] = enc(9, 1, 0);
        for (int i = 1; i <= 5; i++) prog[i] = enc(0, 1, 1);
        prog[6] = enc(4, 2, 2);
        prog[7] = enc(8, 3, 1);
        prog[8] = enc(6, 3, 3);
        prog[9] = enc(6, 3, 2);
        prog[10] = enc(5, 0, 3);
        prog[8'h20] = enc(8, 2, 3);
        prog[8'h21] = enc(8, 2, 2);
        prog[8'h22] = enc(5, 2, 3);
        prog[8'h23] = enc(9, 0, 0);
        prog[8'h24] = enc(7, 0, 1);
        prog[8'h25] = enc(11, 0, 0);
        prog[8'h7F] = enc(9, 2, 0);
        prog[8'h80] = enc(8, 2, 3);
        prog[8'h81] = enc(8, 2, 2);
        prog[8'h82] = enc(11, 2, 0);
        prog[8'hFF] = enc(0, 3, 3);
        pulse_start();
        for (int i = 0; i < 5; i++) do_instr(0);
        chk("t2_model_r1_f0", 16'(m_reg[1]), 16'h00F0);
        do_instr(1);
        chk("t2_model_r1_e0", 16'(m_reg[1]), 16'h00E0);
        chk("t2_ov_after_add", 16'(ov_flag), 16'h0001);
        do_instr(0);
        chk("t2_ov_after_xor", 16'(ov_flag), 16'h0001);

        // eq0 taken to R3=20, then not taken
        for (int i = 0; i < 4; i++) do_instr(0);
        chk("t3_taken_pc", 16'(pc), 16'h0020);
        for (int i = 0; i < 3; i++) do_instr(0);
        chk("t3_nottaken_pc", 16'(pc), 16'h0023);

        // jmp to 7F, fetch there with 4 wait cycles
        for (int i = 0; i < 3; i++) do_instr(0);
        chk("t4_jmp_pc", 16'(pc), 16'h007F);
        do_instr(4);
        for (int i = 0; i < 3; i++) do_instr(0);
        chk("t5_jmp_ff", 16'(pc), 16'h00FF);

        // add at FF wraps the pc; NOP at 0 writes nothing
        prog[0] = enc(13, 1, 1);
        prog[1] = enc(15, 0, 0);
        do_instr(0);
        chk("t5_wrap_pc", 16'(pc), 16'h0000);
        chk("t5_model_r3", 16'(m_reg[3]), 16'h0040);
        do_instr(2);
        chk("t5_nop_pc", 16'(pc), 16'h0001);
        do_instr(0);
        cyc();

        // Reset during EXEC of a write instruction
        prog[0] = enc(9, 1, 0);
        pulse_start();
        bus.imem_ack = 1'b1;
        bus.imem_data = prog[0];
        cyc();
        bus.imem_ack = 1'b0;
        m_ir = prog[0]; e_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 16'(busy), 16'h0000);
        chk("t6_rst_pc", 16'(pc), 16'h0000);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset while a fetch is outstanding drops imem_req at once
        pulse_start();
        bus.imem_ack = 1'b0;
        cyc();
        chk("t6_req_before", 16'(bus.imem_req), 16'h0001);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_async_drop", 16'(bus.imem_req), 16'h0000);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Random program
        for (int i = 0; i < 256; i++) prog[i] = 9'($urandom);
        rnd_start = 1'b1;
        pulse_start();
        for (int n = 0; n < 700; n++) begin
            if (e_halted) begin
                repeat ($urandom_range(0, 2)) cyc();
                pulse_start();
            end else begin
                do_instr($urandom_range(0, 3));
            end
        end
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle instruction sequencer that drives the 8-bit ALU. It fetches 9-bit instructions from instruction memory over a req/ack handshake, decodes them into ALU opcode/operand/constant inputs, and consumes the ALU result, overflow and branch-taken outputs. It writes results back into a 4x8 register file and updates the PC. It sits between instruction memory and the ALU as the initiator of every ALU operation.

## Interface
- No parameters (widths fixed: data 8, instruction 9, PC 8, 4 registers).
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT
- imem_req  out  1  fetch request; holds until ack
- imem_addr  out  8  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  9  instruction: [8:5] opcode, [4:3] rd (also rs1), [2:1] rs2 / constant, [0] reserved
- alu_opcode  out  4  to ALU opcode
- alu_rs1 / alu_rs2  out  8 each  R[rd], R[rs2]
- alu_constant  out  2  instruction [2:1]
- alu_out  in  8  ALU result
- alu_overflow  in  1  ALU carry-out (valid for opcode 0000 only)
- alu_branch_taken  in  1  ALU taken (valid for 0101, 1011 only)
- busy  out  1  high in FETCH/EXEC/WB
- halted  out  1  high in HALT
- pc  out  8  current PC
- ov_flag  out  1  overflow of most recent add
- instr_count  out  16  retired instructions, saturating
- dbg_sel  in  2 / dbg_data  out  8  combinational register-file read

## Operation
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE/HALT + start: pc<=0, instr_count<=0, ov_flag<=0, go FETCH. Registers are preserved. start in other states is ignored.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, capture imem_data into IR and go EXEC.
- EXEC: ALU inputs are driven from IR and the register file. At the end of the cycle, latch alu_out, alu_overflow and alu_branch_taken into result registers. Go WB.
- WB:
  - Write opcodes 0000-0100, 0110-1010 and 1100: R[rd]<=latched result; pc<=pc+1.
  - 0000 also sets ov_flag<=latched overflow. Other opcodes leave ov_flag unchanged.
  - 0101 (eq0): no write. If taken, pc<=R[rs2]; else pc<=pc+1.
  - 1011 (jmp): no write; pc<=latched result (R[rd]).
  - 1101, 1110: NOP; pc<=pc+1.
  - 1111: HALT; pc unchanged.
  - instr_count increments for all opcodes including 1111, saturating at 16'hFFFF.
  - Next state: HALT for 1111, otherwise FETCH.
- Branch-taken is ignored for all opcodes except 0101/1011, because the ALU does not define it there.
- pc+1 wraps 8'hFF -> 8'h00.
- The register file has no reset value requirement beyond reset to 0. dbg_data = R[dbg_sel].

## Timing
- Reset (async assert, sync release): state IDLE, pc 0, IR 0, all registers 0, imem_req 0, busy 0, halted 0, ov_flag 0, instr_count 0.
- When IR=0, alu_opcode/alu_rs1/alu_rs2/alu_constant reflect R[0] operands and opcode 0000. They are harmless because no write occurs outside WB.
- Minimum 3 cycles per instruction (ack in first FETCH cycle). Each extra FETCH wait cycle adds 1 cycle.
- imem_addr is stable while imem_req=1. imem_req drops the cycle after ack.
- ALU inputs are stable throughout EXEC and WB, derived only from IR and registers.
- Register write and pc update occur on the WB->next edge. The next FETCH sees the updated pc.
- rd==rs2 is legal: operands are read before the write.
- rst_n low mid-instruction aborts immediately. There is no partial write, and imem_req drops asynchronously.
- busy=1 exactly in FETCH, EXEC and WB. halted=1 exactly in HALT.

## Test plan
- Reset then start; imem returns 0_00_00_0 at pc0 and 1111 at pc1 -> 3-cycle retire, then halted=1, pc=1, instr_count=2.
- Seed R1=8'hF0 via add chain; add rd=1 rs2=1 with R1=F0 -> R1=8'hE0, ov_flag=1. Following xor leaves ov_flag=1.
- eq0 with R[rd]=0 and R[rs2]=8'h20 -> pc=8'h20. With R[rd]=5 -> pc=pc+1; no register changes in either case.
- jmp with R[rd]=8'h7F -> next imem_addr=8'h7F. Also hold imem_ack low 4 cycles -> imem_addr held at 7F, retire delayed by 4.
- pc=8'hFF with add -> next fetch at 8'h00. NOP at 8'h00 -> pc=1, no register write.
- Assert rst_n low during EXEC of a write instruction -> register unchanged, all outputs at reset values. start pulse during busy -> ignored.
